// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and constants for the forwarding / load-use hazard unit.
//   fsm_state_e      : hazard FSM states (IDLE, HOLD)
//   FWD_NONE         : forward-select value meaning "use the register file"
//   ZERO_REG_DEFAULT : register that is never forwarded or hazarded (XZR)
//   fwd_sel_w(n)     : width of one forward-select field for n producer stages
package fwd_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } fsm_state_e;

    localparam int unsigned FWD_NONE         = 0;
    localparam int unsigned ZERO_REG_DEFAULT = 31;

    // One code per stage plus the "no forward" code.
    function automatic int unsigned fwd_sel_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: pipeline-side bundle for fwd_hazard_unit.
//   IDEX_src, Pipe_RegWrite, Pipe_WriteRegister : EX operands and producer stages
//   IDEX_MemRead, IDEX_rd, IFID_src, IFID_src_valid, Mem_busy : hazard inputs
//   Forward, Stall, PCWrite, IFID_Write, IDEX_Bubble : unit outputs
//   Stat_clr, Stat_stalls, Stat_forwards : present only with FWD_HAZARD_STATS_EN
// Modports: slave = the hazard unit, master = the pipeline driving it.
interface fwd_hazard_unit_if
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned SEL_W      = fwd_sel_w(NUM_STAGES)
);

    logic [NUM_SRC*REG_AW-1:0]    IDEX_src;
    logic [NUM_STAGES-1:0]        Pipe_RegWrite;
    logic [NUM_STAGES*REG_AW-1:0] Pipe_WriteRegister;
    logic                         IDEX_MemRead;
    logic [REG_AW-1:0]            IDEX_rd;
    logic [NUM_SRC*REG_AW-1:0]    IFID_src;
    logic [NUM_SRC-1:0]           IFID_src_valid;
    logic                         Mem_busy;

    logic [NUM_SRC*SEL_W-1:0]     Forward;
    logic                         Stall;
    logic                         PCWrite;
    logic                         IFID_Write;
    logic                         IDEX_Bubble;

`ifdef FWD_HAZARD_STATS_EN
    logic                         Stat_clr;
    logic [31:0]                  Stat_stalls;
    logic [31:0]                  Stat_forwards;

    modport slave (
        input  IDEX_src, Pipe_RegWrite, Pipe_WriteRegister, IDEX_MemRead, IDEX_rd,
        input  IFID_src, IFID_src_valid, Mem_busy, Stat_clr,
        output Forward, Stall, PCWrite, IFID_Write, IDEX_Bubble, Stat_stalls, Stat_forwards
    );

    modport master (
        output IDEX_src, Pipe_RegWrite, Pipe_WriteRegister, IDEX_MemRead, IDEX_rd,
        output IFID_src, IFID_src_valid, Mem_busy, Stat_clr,
        input  Forward, Stall, PCWrite, IFID_Write, IDEX_Bubble, Stat_stalls, Stat_forwards
    );
`else
    modport slave (
        input  IDEX_src, Pipe_RegWrite, Pipe_WriteRegister, IDEX_MemRead, IDEX_rd,
        input  IFID_src, IFID_src_valid, Mem_busy,
        output Forward, Stall, PCWrite, IFID_Write, IDEX_Bubble
    );

    modport master (
        output IDEX_src, Pipe_RegWrite, Pipe_WriteRegister, IDEX_MemRead, IDEX_rd,
        output IFID_src, IFID_src_valid, Mem_busy,
        input  Forward, Stall, PCWrite, IFID_Write, IDEX_Bubble
    );
`endif

endinterface

// File: rtl/fwd_select.sv
// fwd_select: single-operand forwarding priority matcher.
//   src       : EX-stage source register number
//   reg_write : per-stage producer write enable
//   write_reg : per-stage producer destination, stage k at [k*REG_AW +: REG_AW]
//   sel       : 0 = register file, k+1 = forward from stage k (youngest match wins)
module fwd_select
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned ZERO_REG   = ZERO_REG_DEFAULT,
    parameter int unsigned SEL_W      = fwd_sel_w(NUM_STAGES)
) (
    input  logic [REG_AW-1:0]            src,
    input  logic [NUM_STAGES-1:0]        reg_write,
    input  logic [NUM_STAGES*REG_AW-1:0] write_reg,
    output logic [SEL_W-1:0]             sel
);

    logic src_is_zero;

    assign src_is_zero = (src == REG_AW'(ZERO_REG));

    // Walk from oldest to youngest so the youngest match is the last write.
    always_comb begin
        sel = SEL_W'(FWD_NONE);
        for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
            if (!src_is_zero && reg_write[k] && (write_reg[k*REG_AW +: REG_AW] == src)) begin
                sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand forwarding plus load-use hazard stall FSM.
//   Clk, Rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : fwd_hazard_unit_if.slave carrying operands, producers, hazard inputs
//                and Forward / Stall / PCWrite / IFID_Write / IDEX_Bubble outputs
// Optional: define FWD_HAZARD_STATS_EN to add saturating Stat_stalls / Stat_forwards
// counters with a synchronous Stat_clr.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned NUM_STAGES   = 2,
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned ZERO_REG     = ZERO_REG_DEFAULT,
    parameter int unsigned SEL_W        = fwd_sel_w(NUM_STAGES)
) (
    input logic             Clk,
    input logic             Rst_n,
    fwd_hazard_unit_if.slave bus
);

    logic [NUM_SRC*SEL_W-1:0] fwd;
    logic                     src_hit;
    logic                     hz;
    logic                     stall;
    logic                     bubble;
    fsm_state_e               state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;

    // ---------------------------------------------------------------- forwarding
    for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_sel
        fwd_select #(
            .REG_AW     (REG_AW),
            .NUM_STAGES (NUM_STAGES),
            .ZERO_REG   (ZERO_REG),
            .SEL_W      (SEL_W)
        ) u_sel (
            .src       (bus.IDEX_src[i*REG_AW +: REG_AW]),
            .reg_write (bus.Pipe_RegWrite),
            .write_reg (bus.Pipe_WriteRegister),
            .sel       (fwd[i*SEL_W +: SEL_W])
        );
    end

    assign bus.Forward = fwd;

    // ------------------------------------------------------------ hazard detect
    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (bus.IFID_src_valid[i] && (bus.IFID_src[i*REG_AW +: REG_AW] == bus.IDEX_rd)) begin
                src_hit = 1'b1;
            end
        end
    end

    assign hz = bus.IDEX_MemRead && (bus.IDEX_rd != REG_AW'(ZERO_REG)) && src_hit;

    // ----------------------------------------------------------------- stall FSM
    // The IDLE cycle that detects the hazard is the first stall cycle; HOLD covers
    // the remaining LOAD_LATENCY-1 cycles, so cnt starts at LOAD_LATENCY-2.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hz) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (LOAD_LATENCY > 1) begin
                        state_d = HOLD;
                        cnt_d   = 4'(LOAD_LATENCY - 2);
                    end
                end
            end
            HOLD: begin
                stall  = 1'b1;
                bubble = 1'b1;
                // Mem_busy freezes the countdown and so extends the stall.
                if (!bus.Mem_busy) begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Stall       = stall;
    assign bus.PCWrite     = ~stall;
    assign bus.IFID_Write  = ~stall;
    assign bus.IDEX_Bubble = bubble;

`ifdef FWD_HAZARD_STATS_EN
    // --------------------------------------------------------------- statistics
    logic [31:0] stat_stalls_q;
    logic [31:0] stat_forwards_q;
    logic        any_fwd;

    assign any_fwd = |fwd;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stat_stalls_q   <= '0;
            stat_forwards_q <= '0;
        end else if (bus.Stat_clr) begin
            stat_stalls_q   <= '0;
            stat_forwards_q <= '0;
        end else begin
            if (stall && (stat_stalls_q != '1)) begin
                stat_stalls_q <= stat_stalls_q + 32'd1;
            end
            if (any_fwd && (stat_forwards_q != '1)) begin
                stat_forwards_q <= stat_forwards_q + 32'd1;
            end
        end
    end

    assign bus.Stat_stalls   = stat_stalls_q;
    assign bus.Stat_forwards = stat_forwards_q;
`endif

endmodule
